form_wave_gen: RTL and testbench

Parametrised DDS waveform generator, successor to the fixed 32-bit form shaper. It contains its own phase accumulator with phase offset and selects one of six wave shapes. Form changes can be deferred to the next phase wrap so they are glitch-free. Amplitude is scaled in a two-stage registered pipeline, and a wrap-aligned SYNC strobe is produced. It sits between the control register block and the DAC/mixer path.

---
 rtl/form_wave_gen.sv | 76 +++++++
 tb/tb_form_wave_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/form_wave_gen.sv
// form_wave_gen: DDS waveform generator with glitch-free form switching, amplitude scaling and wrap SYNC
//   CLK, RESET (async, active low)
//   EN        : accumulator advance enable
//   FREQ      : phase increment per enabled cycle
//   PHASE_OFS : phase offset applied after the accumulator
//   FORM      : requested shape (saw, reverse saw, triangle, square, pulse, noise)
//   PULSE_W   : pulse high width for the pulse shape
//   AMP       : unsigned amplitude, all-ones = unity
//   DOUT      : registered sample, SYNC : first post-wrap sample strobe, FORM_ACT : applied form
module form_wave_gen #(
  parameter int PHASE_W = 32,
  parameter int OUT_W = 16,
  parameter int PW_W = 8,
  parameter int SYNC_MODE = 1,
  parameter logic [31:0] LFSR_SEED = 32'hACE1ACE1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               EN,
  input  logic [PHASE_W-1:0] FREQ,
  input  logic [PHASE_W-1:0] PHASE_OFS,
  input  logic [2:0]         FORM,
  input  logic [PW_W-1:0]    PULSE_W,
  input  logic [OUT_W-1:0]   AMP,
  output logic [OUT_W-1:0]   DOUT,
  output logic               SYNC,
  output logic [2:0]         FORM_ACT
);
  logic [PHASE_W-1:0] acc, p;
  logic [PHASE_W:0] sum;
  logic wrap, w1, w2;
  logic [OUT_W-1:0] t, u, noise, shape_d, shape_q;
  logic [PW_W-1:0] pw_ph;
  logic [31:0] lfsr;
  logic [OUT_W:0] amp1;
  logic [2*OUT_W:0] prod;
  assign sum = {1'b0, acc} + {1'b0, FREQ};
  assign wrap = EN & sum[PHASE_W];
  assign p = acc + PHASE_OFS;
  // shifts instead of part-selects keep the unused low phase bits out of the slices
  assign t = OUT_W'(p >> (PHASE_W - OUT_W));
  assign u = OUT_W'(p >> (PHASE_W - 1 - OUT_W));
  assign pw_ph = PW_W'(p >> (PHASE_W - PW_W));
  assign noise = OUT_W'(lfsr >> (32 - OUT_W));
  assign amp1 = {1'b0, AMP} + (OUT_W+1)'(1);
  assign prod = (2*OUT_W+1)'(shape_q) * (2*OUT_W+1)'(amp1);
  always_comb begin
    shape_d = '0;
    case (FORM_ACT)
      3'b000: shape_d = t;
      3'b001: shape_d = ~t;
      3'b010: shape_d = p[PHASE_W-1] ? ~u : u;
      3'b011: shape_d = p[PHASE_W-1] ? '1 : '0;
      3'b100: shape_d = (pw_ph < PULSE_W) ? '1 : '0;
      3'b101: shape_d = noise;
      default: shape_d = '0;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      acc <= '0;
      FORM_ACT <= '0;
      shape_q <= '0;
      DOUT <= '0;
      {SYNC, w2, w1} <= '0;
      lfsr <= LFSR_SEED;
    end else begin
      acc <= EN ? sum[PHASE_W-1:0] : acc;
      // form_act updates on the same edge as the post-wrap acc, so the new form starts on that sample
      FORM_ACT <= (SYNC_MODE == 0 || wrap || !EN) ? FORM : FORM_ACT;
      shape_q <= shape_d;
      DOUT <= OUT_W'(prod >> OUT_W);
      {SYNC, w2, w1} <= {w2, w1, wrap};
      lfsr <= wrap ? ((lfsr >> 1) ^ (lfsr[0] ? 32'h80200003 : 32'h0)) : lfsr;
    end
endmodule

// File: tb/tb_form_wave_gen.sv
// tb_form_wave_gen: directed bench for form_wave_gen with a per-cycle reference model for both form-latch modes
module tb_form_wave_gen;
  logic CLK = 0, RESET = 0, EN = 0;
  logic [31:0] FREQ = 0, PHASE_OFS = 0;
  logic [2:0] FORM = 0;
  logic [7:0] PULSE_W = 0;
  logic [15:0] AMP = 16'hFFFF;
  logic [15:0] dout1, dout0;
  logic sync1, sync0;
  logic [2:0] fa1, fa0;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  form_wave_gen #(.SYNC_MODE(1)) u1 (.CLK(CLK), .RESET(RESET), .EN(EN), .FREQ(FREQ), .PHASE_OFS(PHASE_OFS),
    .FORM(FORM), .PULSE_W(PULSE_W), .AMP(AMP), .DOUT(dout1), .SYNC(sync1), .FORM_ACT(fa1));
  form_wave_gen #(.SYNC_MODE(0)) u0 (.CLK(CLK), .RESET(RESET), .EN(EN), .FREQ(FREQ), .PHASE_OFS(PHASE_OFS),
    .FORM(FORM), .PULSE_W(PULSE_W), .AMP(AMP), .DOUT(dout0), .SYNC(sync0), .FORM_ACT(fa0));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] shape(input logic [31:0] ph, input logic [2:0] f, input logic [7:0] pw, input logic [31:0] lf);
    logic [31:0] half;
    half = (ph / 32'd32768) % 32'd65536;
    case (f)
      3'd0: return 16'(ph / 32'd65536);
      3'd1: return 16'(32'd65535 - ph / 32'd65536);
      3'd2: return 16'(ph < 32'h80000000 ? half : 32'd65535 - half);
      3'd3: return ph >= 32'h80000000 ? 16'hFFFF : 16'h0;
      3'd4: return (ph / 32'h01000000) < 32'(pw) ? 16'hFFFF : 16'h0;
      3'd5: return 16'(lf / 32'd65536);
      default: return 16'h0;
    endcase
  endfunction
  function automatic logic [15:0] scale(input logic [15:0] s, input logic [15:0] a);
    logic [63:0] pr;
    pr = 64'(s) * (64'(a) + 64'd1);
    return pr[31:16];
  endfunction
  logic [31:0] m_acc = 0, m_lfsr = 32'hACE1ACE1;
  logic [2:0] mf1 = 0, mf0 = 0;
  logic [15:0] ms1 = 0, ms0 = 0, md1 = 0, md0 = 0;
  logic mw1 = 0, mw2 = 0, msy = 0, m_wrap;
  assign m_wrap = EN && (64'(m_acc) + 64'(FREQ) > 64'hFFFFFFFF);
  always @(posedge CLK or negedge RESET)
    if (!RESET) begin
      m_acc <= 0; m_lfsr <= 32'hACE1ACE1; mf1 <= 0; mf0 <= 0;
      ms1 <= 0; ms0 <= 0; md1 <= 0; md0 <= 0; mw1 <= 0; mw2 <= 0; msy <= 0;
    end else begin
      md1 <= scale(ms1, AMP);
      md0 <= scale(ms0, AMP);
      msy <= mw2; mw2 <= mw1; mw1 <= m_wrap;
      ms1 <= shape(m_acc + PHASE_OFS, mf1, PULSE_W, m_lfsr);
      ms0 <= shape(m_acc + PHASE_OFS, mf0, PULSE_W, m_lfsr);
      mf1 <= (m_wrap || !EN) ? FORM : mf1;
      mf0 <= FORM;
      m_acc <= EN ? m_acc + FREQ : m_acc;
      m_lfsr <= m_wrap ? ((m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h80200003 : 32'h0)) : m_lfsr;
    end
  always @(negedge CLK) begin
    check("model_dout1", 32'(dout1), 32'(md1));
    check("model_sync1", 32'(sync1), 32'(msy));
    check("model_form1", 32'(fa1), 32'(mf1));
    check("model_dout0", 32'(dout0), 32'(md0));
    check("model_sync0", 32'(sync0), 32'(msy));
    check("model_form0", 32'(fa0), 32'(mf0));
  end
  // leaves the bench just after the first edge past reset release (EN=0 on that edge)
  task automatic restart(input logic [2:0] f, input logic [31:0] fr, input logic [31:0] ofs);
    @(negedge CLK);
    RESET = 0; EN = 0; FORM = f; FREQ = fr; PHASE_OFS = ofs;
    repeat (2) @(negedge CLK);
    RESET = 1;
    @(negedge CLK);
    EN = 1;
  endtask
  task automatic count_high(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge CLK);
      if (dout1 == 16'hFFFF) c++;
    end
  endtask
  logic [15:0] tri_tab [4] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF};
  int c, e;
  initial begin
    repeat (2) @(negedge CLK);
    check("reset_dout", 32'(dout1), 32'h0);
    check("reset_sync", 32'(sync1), 32'h0);
    check("reset_form", 32'(fa1), 32'h0);
    restart(3'd0, 32'h01000000, 32'h0);
    for (int i = 2; i <= 259; i++) begin
      @(negedge CLK);
      e = i < 4 ? 0 : ((i - 3) % 256) * 256;
      if (i < 6 || i > 256) begin
        check("saw_dout", 32'(dout1), 32'(e));
        check("saw_sync", 32'(sync1), 32'(i == 259));
      end
    end
    restart(3'd2, 32'h40000000, 32'h0);
    for (int i = 2; i <= 13; i++) begin
      @(negedge CLK);
      if (i >= 4) check("tri_dout", 32'(dout1), 32'(i <= 9 ? tri_tab[(i - 3) % 4] : tri_tab[(i - 1) % 4]));
      if (i == 7) check("tri_sync", 32'(sync1), 32'h1);
      if (i == 8) PHASE_OFS = 32'h80000000;
    end
    restart(3'd0, 32'h01000000, 32'h0);
    for (int i = 2; i <= 387; i++) begin
      @(negedge CLK);
      if (i == 102) check("imm_saw", 32'(dout0), 32'h6300);
      if (i == 103) begin
        check("imm_sq", 32'(dout0), 32'h0);
        check("def_saw", 32'(dout1), 32'h6400);
      end
      if (i == 200) begin
        check("def_pend", 32'(fa1), 32'h0);
        check("imm_form", 32'(fa0), 32'h3);
      end
      if (i == 258) check("def_last", 32'(dout1), 32'hFF00);
      if (i == 259) begin
        check("def_wrap", 32'(dout1), 32'h0);
        check("def_sync", 32'(sync1), 32'h1);
        check("def_form", 32'(fa1), 32'h3);
      end
      if (i == 386) check("def_low", 32'(dout1), 32'h0);
      if (i == 387) check("def_high", 32'(dout1), 32'hFFFF);
      if (i == 100) FORM = 3'd3;
    end
    PULSE_W = 8'h40;
    restart(3'd4, 32'h01000000, 32'h0);
    @(negedge CLK);
    count_high(256, c);
    check("pw_40", 32'(c), 32'd64);
    PULSE_W = 8'h00;
    repeat (2) @(negedge CLK);
    count_high(256, c);
    check("pw_00", 32'(c), 32'd0);
    PULSE_W = 8'hFF;
    repeat (2) @(negedge CLK);
    count_high(256, c);
    check("pw_ff", 32'(c), 32'd255);
    restart(3'd0, 32'h0, 32'hFF000000);
    repeat (3) @(negedge CLK);
    check("amp_unity", 32'(dout1), 32'hFF00);
    AMP = 16'h7FFF; EN = 0;
    @(negedge CLK);
    check("amp_half", 32'(dout1), 32'h7F80);
    AMP = 16'h0000;
    @(negedge CLK);
    check("amp_zero", 32'(dout1), 32'h0);
    AMP = 16'hFFFF; EN = 1; FORM = 3'd3;
    repeat (5) @(negedge CLK);
    check("f0_hold", 32'(fa1), 32'h0);
    check("f0_imm", 32'(fa0), 32'h3);
    EN = 0;
    @(negedge CLK);
    check("f0_en0", 32'(fa1), 32'h3);
    for (int r = 0; r < 2; r++) begin
      restart(3'd5, 32'h40000000, 32'h0);
      for (int i = 2; i <= 8; i++) begin
        @(negedge CLK);
        if (i == 3 || i == 6) check("noise_seed", 32'(dout1), 32'hACE1);
        if (i == 7) begin
          check("noise_step", 32'(dout1), 32'hD650);
          check("noise_sync", 32'(sync1), 32'h1);
        end
        if (i == 8) check("noise_hold", 32'(dout1), 32'hD650);
      end
      if (r == 0) begin
        #2 RESET = 0;
        #1;
        check("mid_rst_dout", 32'(dout1), 32'h0);
        check("mid_rst_sync", 32'(sync1), 32'h0);
        check("mid_rst_form", 32'(fa1), 32'h0);
        check("mid_rst_dout0", 32'(dout0), 32'h0);
        check("mid_rst_form0", 32'(fa0), 32'h0);
      end
    end
    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
